param_rev_counter: RTL and testbench
====================================

Name: param_rev_counter

Overview:
Parametrised, loadable, reversible (up/down) counter with ripple-carry output, generalising the fixed 16-bit reversible counter.
- Adds programmable width and modulus, wrap or saturate mode, count enable, parallel load, and a sticky overflow flag.
- Used standalone as a timebase or display counter, or cascaded by feeding Rc into the next stage's en.

Parameters:
WIDTH, 16, counter width in bits (2..32)
MODULUS, 2**WIDTH, count range is 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
SATURATE, 0, 0 = wrap at range limits; 1 = hold at range limits

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
en  in  1  count enable; also the cascade input from a lower stage's Rc
s  in  1  direction: 1 = up, 0 = down
ld  in  1  synchronous parallel load
d  in  WIDTH  load value
clr_ovf  in  1  synchronous clear of ovf
cnt  out  WIDTH  current count (registered)
Rc  out  1  ripple carry/borrow (combinational)
ovf  out  1  sticky overflow/underflow flag (registered)

Behaviour:
- Reset (rst_n=0, asynchronous): cnt=0, ovf=0 immediately; no clock needed. Rc follows from cnt=0, i.e. Rc = en & ~s & ~ld.
- Release of rst_n is synchronous by use; the first counting edge is the first rising clk with rst_n=1.
- Per-edge priority is ld > en > hold.
- ld=1: cnt <= d, or MODULUS-1 when d >= MODULUS (clamp). en and s are ignored. ovf is unaffected except by clr_ovf.
- en=1, s=1: cnt <= cnt+1. At cnt=MODULUS-1:
  - SATURATE=0: cnt <= 0 (wrap).
  - SATURATE=1: cnt holds.
- en=1, s=0: cnt <= cnt-1. At cnt=0:
  - SATURATE=0: cnt <= MODULUS-1.
  - SATURATE=1: cnt holds.
- en=0, ld=0: cnt holds.
- Direction may change on any cycle; it takes effect on the same edge. There is no pipeline and no extra latency.
- Rc = en & ~ld & ((s & cnt==MODULUS-1) | (~s & cnt==0)).
  - Purely combinational, and asserted in both modes.
  - Its meaning is "this edge reaches or passes the limit"; it drives the next stage's en for correct cascading.
- ovf set: on any edge where Rc=1, i.e. a wrap in mode 0 or a blocked step in mode 1.
- ovf clear: on an edge with clr_ovf=1.
- Simultaneous set and clr_ovf: set wins, so ovf=1.
- ovf is sticky otherwise.
- Counter arithmetic is WIDTH bits. The limit compare uses the constant MODULUS-1, computed at elaboration.
- MODULUS = 2**WIDTH must behave identically to native overflow.
- Out-of-range cnt is unreachable, because load clamps.

Decomposition:
- Package rev_counter_pkg: direction constants DIR_UP=1'b1, DIR_DN=1'b0; mode constants MODE_WRAP=0, MODE_SAT=1; function clamp_load(d, MODULUS).
- One sub-module, rev_counter_tc: combinational terminal-count detector. Inputs cnt, s, en, ld; outputs Rc, at_max, at_min. It is parametrised by WIDTH and MODULUS and reused by the next-value logic.
- Top level: next-state mux, cnt register, ovf register.

Test Plan:
1. Reset mid-count.
   - Setup: WIDTH=4, MODULUS=10, en=1, s=1.
   - Drive rst_n=0 between clock edges after cnt reaches 6.
   - Required: cnt=0 and ovf=0 with no clk edge. With rst_n=0 and en=1, s=1, ld=0, Rc=0.
2. Up-count wrap, SATURATE=0, MODULUS=10.
   - Stimulus: en=1, s=1 for 12 edges from 0.
   - Required sequence: 1..9, 0, 1, 2.
   - Rc=1 exactly while cnt=9. ovf becomes 1 after the 9→0 edge.
3. Down-count and direction flip.
   - Stimulus: from cnt=1, s=0 for 2 edges, then s=1 for 1 edge.
   - Required: cnt 1→0→9→0.
   - Rc=1 while cnt=0 with s=0, and again while cnt=9 with s=1.
4. Saturate mode, MODULUS=10, SATURATE=1.
   - Stimulus: count up from 8 for 3 edges.
   - Required: cnt 9, 9, 9; Rc=1 while at 9; ovf=1.
   - Then s=0 at cnt=0 for 2 edges: cnt holds at 0.
5. Load priority and clamp.
   - Stimulus: ld=1, en=1, d=4'd13, MODULUS=10.
   - Required: cnt=9 after the edge, and Rc=0 during the load cycle.
   - Then ld=1, d=3: cnt=3.
6. ovf clear collision.
   - Setup: ovf=1; assert clr_ovf=1 on a non-terminal edge.
   - Required: ovf=0.
   - Then assert clr_ovf=1 on an edge with Rc=1: ovf stays 1.
   - Cascade check: two 4-bit instances with MODULUS=10, low-stage Rc driving high-stage en, count 0→99→0. The high stage increments only on the low stage's 9→0 edges.

Source files
------------

// File: rtl/rev_counter_pkg.sv
// Shared direction/mode encodings and load clamping for the reversible counter family.
package rev_counter_pkg;

  typedef enum logic {DIR_DN = 1'b0, DIR_UP = 1'b1} dir_e;
  typedef enum bit   {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_e;

  // Widened to 64 bits so MODULUS = 2**32 stays representable.
  function automatic logic [63:0] clamp_load(input logic [63:0] d, input logic [63:0] modulus);
    return (d >= modulus) ? modulus - 64'd1 : d;
  endfunction

endpackage

// File: rtl/rev_counter_tc.sv
// Terminal-count detector: range-limit flags and the ripple carry/borrow for cascading.
module rev_counter_tc
  import rev_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter logic [63:0] MODULUS = 64'd1 << WIDTH
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             s,
  input  logic             en,
  input  logic             ld,
  output logic             Rc,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);

  assign at_max = (cnt == MAX);
  assign at_min = (cnt == '0);
  assign Rc     = en & ~ld & (((s == DIR_UP) & at_max) | ((s == DIR_DN) & at_min));

endmodule

// File: rtl/param_rev_counter.sv
// Parametrised loadable up/down counter with wrap or saturate limits and a sticky overflow flag.
module param_rev_counter
  import rev_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter logic [63:0] MODULUS  = 64'd1 << WIDTH,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             s,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] cnt,
  output logic             Rc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);
  localparam bit               SAT = (SATURATE == MODE_SAT);

  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] cnt_next;

  rev_counter_tc #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_tc (
    .cnt    (cnt),
    .s      (s),
    .en     (en),
    .ld     (ld),
    .Rc     (Rc),
    .at_max (at_max),
    .at_min (at_min)
  );

  assign ld_val = WIDTH'(clamp_load(64'(d), MODULUS));

  always_comb begin
    cnt_next = cnt;
    if (ld) begin
      cnt_next = ld_val;
    end else if (en) begin
      if (s == DIR_UP) begin
        if (at_max) cnt_next = SAT ? cnt : '0;
        else        cnt_next = cnt + WIDTH'(1);
      end else begin
        if (at_min) cnt_next = SAT ? cnt : MAX;
        else        cnt_next = cnt - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_next;
  end

  // A limit event on the same edge as clr_ovf keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf <= 1'b0;
    else if (Rc)      ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_param_rev_counter.sv
// Scoreboard bench: wrap, saturate, native-modulus and cascaded instances of param_rev_counter.
module tb_param_rev_counter;

  typedef struct packed {
    logic [7:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int unsigned checks = 0;
  int unsigned errors = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic a_en, a_s, a_ld, a_clr, a_rc, a_ovf;
  logic [3:0] a_d, a_cnt;
  logic b_en, b_s, b_ld, b_clr, b_rc, b_ovf;
  logic [3:0] b_d, b_cnt;
  logic c_en, c_s, c_ld, c_clr, c_rc, c_ovf;
  logic [3:0] c_d, c_cnt;
  logic k_en, lo_rc, lo_ovf, hi_rc, hi_ovf;
  logic [3:0] lo_cnt, hi_cnt;

  param_rev_counter #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .s(a_s), .ld(a_ld), .d(a_d),
    .clr_ovf(a_clr), .cnt(a_cnt), .Rc(a_rc), .ovf(a_ovf));

  param_rev_counter #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .s(b_s), .ld(b_ld), .d(b_d),
    .clr_ovf(b_clr), .cnt(b_cnt), .Rc(b_rc), .ovf(b_ovf));

  param_rev_counter #(.WIDTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .en(c_en), .s(c_s), .ld(c_ld), .d(c_d),
    .clr_ovf(c_clr), .cnt(c_cnt), .Rc(c_rc), .ovf(c_ovf));

  param_rev_counter #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b0)) u_lo (
    .clk(clk), .rst_n(rst_n), .en(k_en), .s(1'b1), .ld(1'b0), .d(4'd0),
    .clr_ovf(1'b0), .cnt(lo_cnt), .Rc(lo_rc), .ovf(lo_ovf));

  param_rev_counter #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b0)) u_hi (
    .clk(clk), .rst_n(rst_n), .en(lo_rc), .s(1'b1), .ld(1'b0), .d(4'd0),
    .clr_ovf(1'b0), .cnt(hi_cnt), .Rc(hi_rc), .ovf(hi_ovf));

  task automatic test_reset();
    rst_n = 1'b0;
    a_en = 0; a_s = 1; a_ld = 0; a_d = 0; a_clr = 0;
    b_en = 0; b_s = 1; b_ld = 0; b_d = 0; b_clr = 0;
    c_en = 0; c_s = 1; c_ld = 0; c_d = 0; c_clr = 0;
    k_en = 0;
    #3;
    checks++; if (a_cnt !== 4'd0 || a_ovf !== 1'b0) begin errors++;
      $display("FAIL reset_init_a: cnt=%0d ovf=%0b expected cnt=0 ovf=0", a_cnt, a_ovf); end
    checks++; if (b_cnt !== 4'd0 || c_cnt !== 4'd0 || lo_cnt !== 4'd0 || hi_cnt !== 4'd0) begin errors++;
      $display("FAIL reset_init_others: b=%0d c=%0d lo=%0d hi=%0d expected all 0", b_cnt, c_cnt, lo_cnt, hi_cnt); end
    @(negedge clk);
    rst_n = 1'b1; a_en = 1; a_s = 1;
    for (int i = 1; i <= 6; i++) begin
      q.push_back('{cnt: 8'(i), ovf: 1'b0});
      @(posedge clk); #1;
      e = q.pop_front();
      checks++; if ({4'd0, a_cnt} !== e.cnt) begin errors++;
        $display("FAIL reset_precount edge %0d: cnt=%0d expected %0d", i, a_cnt, e.cnt); end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_cnt !== 4'd0 || a_ovf !== 1'b0) begin errors++;
      $display("FAIL reset_async: cnt=%0d ovf=%0b expected cnt=0 ovf=0", a_cnt, a_ovf); end
    checks++; if (a_rc !== 1'b0) begin errors++;
      $display("FAIL reset_rc_up: Rc=%0b expected 0", a_rc); end
    a_s = 0; #1;
    checks++; if (a_rc !== 1'b1) begin errors++;
      $display("FAIL reset_rc_down: Rc=%0b expected 1", a_rc); end
    a_en = 0; a_s = 1; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_cnt !== 4'd0) begin errors++;
      $display("FAIL reset_hold: cnt=%0d expected 0", a_cnt); end
  endtask

  task automatic test_up_wrap();
    a_en = 1; a_s = 1;
    for (int i = 1; i <= 12; i++) begin
      #1;
      checks++; if (a_rc !== (((i - 1) % 10) == 9)) begin errors++;
        $display("FAIL up_wrap_rc edge %0d: Rc=%0b expected %0b", i, a_rc, (((i - 1) % 10) == 9)); end
      q.push_back('{cnt: 8'(i % 10), ovf: (i >= 10)});
      @(posedge clk); #1;
      e = q.pop_front();
      checks++; if ({4'd0, a_cnt} !== e.cnt || a_ovf !== e.ovf) begin errors++;
        $display("FAIL up_wrap edge %0d: cnt=%0d ovf=%0b expected cnt=%0d ovf=%0b", i, a_cnt, a_ovf, e.cnt, e.ovf); end
    end
  endtask

  task automatic test_down_flip();
    logic [2:0] dir_t [3] = '{1'b0, 1'b0, 1'b1};
    logic [3:0] cnt_t [3] = '{4'd0, 4'd9, 4'd0};
    logic       rc_t  [3] = '{1'b0, 1'b1, 1'b1};
    logic       ovf_t [3] = '{1'b0, 1'b1, 1'b1};
    a_en = 0; a_ld = 1; a_d = 4'd1; a_clr = 1;
    q.push_back('{cnt: 8'd1, ovf: 1'b0});
    @(posedge clk); #1;
    e = q.pop_front();
    checks++; if ({4'd0, a_cnt} !== e.cnt || a_ovf !== e.ovf) begin errors++;
      $display("FAIL down_setup: cnt=%0d ovf=%0b expected cnt=%0d ovf=%0b", a_cnt, a_ovf, e.cnt, e.ovf); end
    a_ld = 0; a_clr = 0; a_en = 1;
    for (int i = 0; i < 3; i++) begin
      a_s = dir_t[i][0];
      #1;
      checks++; if (a_rc !== rc_t[i]) begin errors++;
        $display("FAIL down_flip_rc step %0d: Rc=%0b expected %0b", i, a_rc, rc_t[i]); end
      q.push_back('{cnt: {4'd0, cnt_t[i]}, ovf: ovf_t[i]});
      @(posedge clk); #1;
      e = q.pop_front();
      checks++; if ({4'd0, a_cnt} !== e.cnt || a_ovf !== e.ovf) begin errors++;
        $display("FAIL down_flip step %0d: cnt=%0d ovf=%0b expected cnt=%0d ovf=%0b", i, a_cnt, a_ovf, e.cnt, e.ovf); end
    end
  endtask

  task automatic test_load_clamp();
    logic [3:0] d_t   [4] = '{4'd13, 4'd3, 4'd10, 4'd9};
    logic [3:0] cnt_t [4] = '{4'd9,  4'd3, 4'd9,  4'd9};
    a_en = 1; a_s = 0; a_ld = 1;
    for (int i = 0; i < 4; i++) begin
      a_d = d_t[i];
      #1;
      checks++; if (a_rc !== 1'b0) begin errors++;
        $display("FAIL load_rc step %0d: Rc=%0b expected 0", i, a_rc); end
      q.push_back('{cnt: {4'd0, cnt_t[i]}, ovf: 1'b1});
      @(posedge clk); #1;
      e = q.pop_front();
      checks++; if ({4'd0, a_cnt} !== e.cnt || a_ovf !== e.ovf) begin errors++;
        $display("FAIL load_clamp d=%0d: cnt=%0d ovf=%0b expected cnt=%0d ovf=%0b", d_t[i], a_cnt, a_ovf, e.cnt, e.ovf); end
    end
    a_ld = 1; a_d = 4'd3; a_en = 0;
    q.push_back('{cnt: 8'd3, ovf: 1'b1});
    @(posedge clk); #1;
    e = q.pop_front();
    checks++; if ({4'd0, a_cnt} !== e.cnt) begin errors++;
      $display("FAIL load_three: cnt=%0d expected %0d", a_cnt, e.cnt); end
    a_ld = 0;
  endtask

  task automatic test_ovf_clear();
    // steps: clr on quiet edge, load 9, clr with Rc=1 (set wins), clr alone
    logic       en_t  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       ld_t  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       clr_t [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] cnt_t [4] = '{4'd3, 4'd9, 4'd0, 4'd0};
    logic       ovf_t [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    a_s = 1; a_d = 4'd9;
    for (int i = 0; i < 4; i++) begin
      a_en = en_t[i]; a_ld = ld_t[i]; a_clr = clr_t[i];
      q.push_back('{cnt: {4'd0, cnt_t[i]}, ovf: ovf_t[i]});
      @(posedge clk); #1;
      e = q.pop_front();
      checks++; if ({4'd0, a_cnt} !== e.cnt || a_ovf !== e.ovf) begin errors++;
        $display("FAIL ovf_clear step %0d: cnt=%0d ovf=%0b expected cnt=%0d ovf=%0b", i, a_cnt, a_ovf, e.cnt, e.ovf); end
    end
    a_en = 0; a_ld = 0; a_clr = 0;
  endtask

  task automatic test_saturate();
    // load 8, up x3, load 0 with clear, down x2, load 15 (clamped)
    logic       en_t  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       s_t   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       ld_t  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] d_t   [7] = '{4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    logic       clr_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       rc_t  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] cnt_t [7] = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd0, 4'd0, 4'd0};
    logic       ovf_t [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      b_en = en_t[i]; b_s = s_t[i]; b_ld = ld_t[i]; b_d = d_t[i]; b_clr = clr_t[i];
      #1;
      checks++; if (b_rc !== rc_t[i]) begin errors++;
        $display("FAIL sat_rc step %0d: Rc=%0b expected %0b", i, b_rc, rc_t[i]); end
      q.push_back('{cnt: {4'd0, cnt_t[i]}, ovf: ovf_t[i]});
      @(posedge clk); #1;
      e = q.pop_front();
      checks++; if ({4'd0, b_cnt} !== e.cnt || b_ovf !== e.ovf) begin errors++;
        $display("FAIL sat step %0d: cnt=%0d ovf=%0b expected cnt=%0d ovf=%0b", i, b_cnt, b_ovf, e.cnt, e.ovf); end
    end
    b_en = 0; b_ld = 1; b_d = 4'd15; b_clr = 0;
    q.push_back('{cnt: 8'd9, ovf: 1'b1});
    @(posedge clk); #1;
    e = q.pop_front();
    checks++; if ({4'd0, b_cnt} !== e.cnt) begin errors++;
      $display("FAIL sat_load_clamp: cnt=%0d expected %0d", b_cnt, e.cnt); end
    b_ld = 0;
  endtask

  task automatic test_native_modulus();
    // MODULUS = 16: load 14, up 3 (15,0,1), down 2 (0,15)
    logic       en_t  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       s_t   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       ld_t  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       rc_t  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] cnt_t [6] = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd0, 4'd15};
    logic       ovf_t [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    c_d = 4'd14;
    for (int i = 0; i < 6; i++) begin
      c_en = en_t[i]; c_s = s_t[i]; c_ld = ld_t[i];
      #1;
      checks++; if (c_rc !== rc_t[i]) begin errors++;
        $display("FAIL native_rc step %0d: Rc=%0b expected %0b", i, c_rc, rc_t[i]); end
      q.push_back('{cnt: {4'd0, cnt_t[i]}, ovf: ovf_t[i]});
      @(posedge clk); #1;
      e = q.pop_front();
      checks++; if ({4'd0, c_cnt} !== e.cnt || c_ovf !== e.ovf) begin errors++;
        $display("FAIL native step %0d: cnt=%0d ovf=%0b expected cnt=%0d ovf=%0b", i, c_cnt, c_ovf, e.cnt, e.ovf); end
    end
    c_en = 0; c_ld = 0;
  endtask

  task automatic test_cascade();
    k_en = 1;
    for (int i = 1; i <= 100; i++) begin
      q.push_back('{cnt: {4'((i / 10) % 10), 4'(i % 10)}, ovf: (i >= 100)});
      @(posedge clk); #1;
      e = q.pop_front();
      checks++; if ({hi_cnt, lo_cnt} !== e.cnt || hi_ovf !== e.ovf) begin errors++;
        $display("FAIL cascade edge %0d: hi=%0d lo=%0d hi_ovf=%0b expected hi=%0d lo=%0d hi_ovf=%0b",
                 i, hi_cnt, lo_cnt, hi_ovf, e.cnt[7:4], e.cnt[3:0], e.ovf); end
    end
    k_en = 0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_flip();
    test_load_clamp();
    test_ovf_clear();
    test_saturate();
    test_native_modulus();
    test_cascade();
    checks++; if (q.size() != 0) begin errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
